psr_cond_unit: RTL and testbench

//  - Consumer end of the ALU flag interface.
//  - Latches the ALU Flags{Z,C,F,N,L} into the processor status register (PSR).
//  - Answers registered condition-code queries for Bcond/Jcond/Scond.
//  - Supports explicit PSR load/read over the 16-bit datapath.
//  - Sits between the ALU flag outputs and the branch/writeback control in the core.

---
 rtl/psr_cond_unit.sv | 128 ++++++++++++
 tb/tb_psr_cond_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/psr_cond_unit.sv
// ============================================================================
//  Module      : psr_cond_unit
//  Description : Processor status register fed by the ALU flags, with a
//                registered condition-code evaluator for branch/jump/set.
//                Optional PSR shadow save/restore under macro PSR_SAVE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module psr_cond_unit #(
    parameter int DATA_W = 16,
    parameter int FLAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              flags_we,
    input  logic              psr_we,
    input  logic [DATA_W-1:0] psr_wdata,
    output logic [DATA_W-1:0] psr_rdata,
    input  logic              cond_req,
    input  logic [3:0]        cond_code,
    output logic              cond_valid,
    output logic              cond_taken,
    input  logic              save,
    input  logic              restore
);

    localparam int c_bit_z = 4;
    localparam int c_bit_c = 3;
    localparam int c_bit_f = 2;
    localparam int c_bit_n = 1;
    localparam int c_bit_l = 0;

    logic [FLAG_W-1:0] r_psr;
    logic [FLAG_W-1:0] w_psr_next;
    logic              r_cond_valid;
    logic              r_cond_taken;
    logic              w_cond_result;
    logic              w_z, w_c, w_f, w_n, w_l;

    // Upper load-data bits carry no state.
    logic w_unused_wdata;
    assign w_unused_wdata = ^psr_wdata[DATA_W-1:FLAG_W];

`ifdef PSR_SAVE_EN
    logic [FLAG_W-1:0] r_shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (save) begin
            r_shadow <= r_psr;
        end
    end

    always_comb begin
        w_psr_next = r_psr;
        if (restore) begin
            w_psr_next = r_shadow;
        end else if (psr_we) begin
            w_psr_next = psr_wdata[FLAG_W-1:0];
        end else if (flags_we) begin
            w_psr_next = alu_flags;
        end
    end
`else
    logic w_unused_ports;
    assign w_unused_ports = save ^ restore;

    always_comb begin
        w_psr_next = r_psr;
        if (psr_we) begin
            w_psr_next = psr_wdata[FLAG_W-1:0];
        end else if (flags_we) begin
            w_psr_next = alu_flags;
        end
    end
`endif

    assign w_z = r_psr[c_bit_z];
    assign w_c = r_psr[c_bit_c];
    assign w_f = r_psr[c_bit_f];
    assign w_n = r_psr[c_bit_n];
    assign w_l = r_psr[c_bit_l];

    // Evaluated on the PSR as registered, so same-cycle flag writes are not seen.
    always_comb begin
        w_cond_result = 1'b0;
        case (cond_code)
            4'b0000: w_cond_result = w_z;
            4'b0001: w_cond_result = ~w_z;
            4'b0010: w_cond_result = w_c;
            4'b0011: w_cond_result = ~w_c;
            4'b0100: w_cond_result = ~w_l & ~w_z;
            4'b0101: w_cond_result = w_l | w_z;
            4'b0110: w_cond_result = ~w_n & ~w_z;
            4'b0111: w_cond_result = w_n | w_z;
            4'b1000: w_cond_result = w_f;
            4'b1001: w_cond_result = ~w_f;
            4'b1010: w_cond_result = w_l;
            4'b1011: w_cond_result = ~w_l;
            4'b1100: w_cond_result = w_n;
            4'b1101: w_cond_result = ~w_n;
            4'b1110: w_cond_result = 1'b1;
            default: w_cond_result = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psr        <= '0;
            r_cond_valid <= 1'b0;
            r_cond_taken <= 1'b0;
        end else begin
            r_psr        <= w_psr_next;
            r_cond_valid <= cond_req;
            r_cond_taken <= cond_req & w_cond_result;
        end
    end

    assign psr_rdata  = {{(DATA_W-FLAG_W){1'b0}}, r_psr};
    assign cond_valid = r_cond_valid;
    assign cond_taken = r_cond_taken;

endmodule

`default_nettype wire

// File: tb/tb_psr_cond_unit.sv
// ============================================================================
//  Module      : tb_psr_cond_unit
//  Description : Scoreboard bench for psr_cond_unit with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psr_cond_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  alu_flags;
    logic        flags_we;
    logic        psr_we;
    logic [15:0] psr_wdata;
    logic [15:0] psr_rdata;
    logic        cond_req;
    logic [3:0]  cond_code;
    logic        cond_valid;
    logic        cond_taken;
    logic        save;
    logic        restore;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];

    psr_cond_unit #(.DATA_W(16), .FLAG_W(5)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_flags  (alu_flags),
        .flags_we   (flags_we),
        .psr_we     (psr_we),
        .psr_wdata  (psr_wdata),
        .psr_rdata  (psr_rdata),
        .cond_req   (cond_req),
        .cond_code  (cond_code),
        .cond_valid (cond_valid),
        .cond_taken (cond_taken),
        .save       (save),
        .restore    (restore)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected result per cond_valid pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cond_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_cond_valid: got 1, expected 0");
                    end else begin
                        check("cond_taken", {15'd0, cond_taken}, {15'd0, exp_q.pop_front()});
                    end
                end else begin
                    check("taken_idle", {15'd0, cond_taken}, 16'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_flags(input logic [4:0] f);
        alu_flags = f;
        flags_we  = 1'b1;
        step();
        flags_we  = 1'b0;
    endtask

    task automatic load_psr(input logic [15:0] d);
        psr_wdata = d;
        psr_we    = 1'b1;
        step();
        psr_we    = 1'b0;
    endtask

    task automatic query(input logic [3:0] code, input bit exp);
        cond_req  = 1'b1;
        cond_code = code;
        exp_q.push_back(exp);
        step();
        cond_req  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; alu_flags = '0; flags_we = 0; psr_we = 0; psr_wdata = '0;
        cond_req = 0; cond_code = '0; save = 0; restore = 0;
        #12;
        check("reset_psr_rdata", psr_rdata, 16'h0000);
        check("reset_cond_valid", {15'd0, cond_valid}, 16'd0);
        check("reset_cond_taken", {15'd0, cond_taken}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Z set: EQ/NE plus other codes on PSR = 10000
        load_flags(5'b10000);
        check("psr_after_flags", psr_rdata, 16'h0010);
        query(4'b0000, 1'b1);
        query(4'b0001, 1'b0);
        query(4'b0100, 1'b0);
        query(4'b0101, 1'b1);
        query(4'b0011, 1'b1);
        query(4'b1000, 1'b0);
        query(4'b1001, 1'b1);
        query(4'b1110, 1'b1);
        query(4'b1111, 1'b0);

        // CMP 0xFFFE vs 0x0001: N=1, L=0
        load_flags(5'b00010);
        query(4'b1100, 1'b1);
        query(4'b1101, 1'b0);
        query(4'b1010, 1'b0);
        query(4'b1011, 1'b1);
        query(4'b0110, 1'b0);
        query(4'b0111, 1'b1);

        // psr_we beats flags_we; upper wdata bits ignored
        psr_wdata = 16'hFFE8; psr_we = 1'b1;
        alu_flags = 5'b00001; flags_we = 1'b1;
        step();
        psr_we = 1'b0; flags_we = 1'b0;
        check("psr_we_priority", psr_rdata, 16'h0008);
        query(4'b0010, 1'b1);
        query(4'b1010, 1'b0);

        // Same-cycle hazard: query sees the old Z
        load_psr(16'h0000);
        alu_flags = 5'b10000; flags_we = 1'b1;
        query(4'b0000, 1'b0);
        flags_we = 1'b0;
        query(4'b0000, 1'b1);

        // Save / restore
        load_psr(16'h0014);
        save = 1'b1; step(); save = 1'b0;
        load_psr(16'h0000);
        check("psr_cleared", psr_rdata, 16'h0000);
        restore = 1'b1; step(); restore = 1'b0;
`ifdef PSR_SAVE_EN
        check("psr_restored", psr_rdata, 16'h0014);
`else
        check("psr_restore_ignored", psr_rdata, 16'h0000);
`endif
        step();
        step();

        // Reset mid-query: pending result dropped
        load_flags(5'b11111);
        cond_req = 1'b1; cond_code = 4'b0000;
        @(posedge clk);
        #1;
        cond_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset_psr_rdata", psr_rdata, 16'h0000);
        check("midreset_cond_valid", {15'd0, cond_valid}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        query(4'b0000, 1'b0);
        step();
        step();

        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
